// File: rtl/mips_mem_pkg.sv
// Shared types and lane helpers for the word-wide data memory access path.
// Big-endian lane numbering: byte lane 0 is bits [31:24].
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

    // Right-shift that brings the addressed lane down to bit 0 (big-endian).
    function automatic logic [4:0] lane_shift(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return {~addr_lo, 3'b000};
            SZ_HALF: return {~addr_lo[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response channel between the MEM stage (master) and mem_access_unit (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_lane_mux.sv
// Combinational lane logic: extract/extend load data and merge sub-word store data
// into a full memory word.
module mem_lane_mux
    import mips_mem_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shift;
    logic [31:0] lane_data;
    logic [31:0] mask;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        shift     = lane_shift(size_i, addr_lo_i);
        lane_data = rword_i >> shift;
        mask      = WORD_MASK;
        load_o    = rword_i;
        case (size_i)
            SZ_BYTE: begin
                mask   = BYTE_MASK;
                load_o = {{24{lane_data[7] & ~unsigned_i}}, lane_data[7:0]};
            end
            SZ_HALF: begin
                mask   = HALF_MASK;
                load_o = {{16{lane_data[15] & ~unsigned_i}}, lane_data[15:0]};
            end
            default: ;
        endcase
        merge_o = (rword_i & ~(mask << shift)) | ((wdata_i & mask) << shift);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer toward a word-only memory, with read-modify-write for sub-word stores.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: trap misaligned/reserved accesses via resp_err.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  req,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write,
    input  logic [31:0]       read
);

    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    size_e             size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       write_data_q, write_data_d;

    logic              accept;
    logic              misalign;
    size_e             req_size_eff;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign accept = (state_q == S_IDLE) && req.req_valid && req_ready_q;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign = (size_e'(req.req_size) == SZ_RSVD)
                   || ((size_e'(req.req_size) == SZ_HALF) && req.req_addr[0])
                   || ((size_e'(req.req_size) == SZ_WORD) && (req.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_size_eff = (size_e'(req.req_size) == SZ_RSVD) ? SZ_WORD : size_e'(req.req_size);

    mem_lane_mux u_lane_mux (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .rword_i    (read),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        write_data_d = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d    = req.req_write;
                    size_d     = req_size_eff;
                    unsigned_d = req.req_unsigned;
                    addr_d     = req.req_addr;
                    wdata_d    = req.req_wdata;
                    cnt_d      = 3'd0;
                    if (misalign) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req.req_write && (req_size_eff == SZ_WORD)) begin
                        state_d      = S_WR;
                        write_data_d = req.req_wdata;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    // The registered write data doubles as the RMW word buffer.
                    if (write_q) begin
                        state_d      = S_WR;
                        write_data_d = merge_data;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        mem_read_d  = (state_d == S_RD);
        mem_write_d = (state_d == S_WR);
        address_d   = (mem_read_d || mem_write_d) ? (addr_d >> 2) : '0;
    end

    // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
        end
    end

    assign req.req_ready  = req_ready_q;
    assign req.resp_valid = resp_valid_q;
    assign req.resp_rdata = resp_rdata_q;
    assign req.resp_err   = resp_err_q;
    assign memRead        = mem_read_q;
    assign memWrite       = mem_write_q;
    assign address        = address_q;
    assign write          = write_data_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-wide data memory interface (clk, memWrite, memRead, address, write, read).
- Accepts load/store requests from the datapath MEM stage and sequences memRead/memWrite toward `mem`.
- Sign/zero-extends byte and halfword loads.
- Performs read-modify-write for byte and halfword stores, because `mem` only stores whole words.
- Big-endian: byte offset 0 maps to bits [31:24].

Parameters:
- RD_LAT, 1, cycles memRead is held before `read` is sampled (1..4).
- ADDR_W, 32, byte-address width of requests and of `address`.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned/reserved access (feature only; else tied 0)
- memRead  out  1  read strobe to mem
- memWrite  out  1  write strobe to mem
- address  out  ADDR_W  word address = req_addr >> 2
- write  out  32  write data to mem
- read  in  32  read data from mem

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = IDLE; req_ready = 1.
  - All other outputs 0.
  - Captured request registers cleared.
- All outputs are registered.
- Accept: req_valid && req_ready at a rising edge latches the request. req_ready drops the next cycle.
- Only one request is outstanding at a time.
- States:
  - IDLE:
    - Store with size 10 -> WR.
    - Any load, or store with size 00/01 -> RD.
  - RD: memRead = 1 and address is held for RD_LAT cycles. On the last cycle, `read` is captured into a word buffer.
    - Load -> RESP.
    - Sub-word store -> WR.
  - WR: memWrite = 1 for exactly one cycle, address held.
    - Word store: write = req_wdata.
    - Sub-word store: write = buffer with the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0]. Lane = addr[1:0] for bytes, addr[1] for halfwords.
    - Next state RESP.
  - RESP: resp_valid = 1 for one cycle; resp_rdata valid in the same cycle. Next state IDLE with req_ready = 1.
- memRead and memWrite are never asserted in the same cycle.
- Latency, counted in cycles after the accept edge:
  - Word store: memWrite in cycle 1, resp_valid in cycle 2.
  - Load: memRead in cycles 1..RD_LAT, resp_valid in cycle RD_LAT+1.
  - Sub-word store: resp_valid in cycle RD_LAT+2.
- Load extraction:
  - Byte: lane = addr[1:0]; lane 0 = [31:24].
  - Half: addr[1]=0 -> [31:16].
  - Extension: sign-extend unless req_unsigned. For word loads req_unsigned is ignored.
- Reserved size 11 is treated as a word access.
- Without the feature, addr low bits are ignored as needed to align: half uses addr[1] only; word forces alignment.
- Reset mid-operation returns to IDLE next edge and drops strobes. An RMW interrupted before WR issues no write.
- req_valid while busy is ignored, not queued. The requester holds it until req_ready.

Optional Feature:
- Macro MEM_ACCESS_MISALIGN_TRAP_EN.
- When defined:
  - IDLE detects size 11, half with addr[0]=1, or word with addr[1:0]!=0.
  - On detection it goes straight to RESP with resp_err = 1 and resp_rdata = 0. No memRead/memWrite is issued; resp_valid comes in cycle 1.
- When undefined: resp_err is constant 0 and alignment is forced as above.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - lane-select constants
- One sub-module, mem_lane_mux: combinational extract/extend for loads and merge for stores, keyed by size and addr[1:0]. The FSM and registers stay in mem_access_unit.

Test Plan:
- After reset, all outputs 0 and req_ready = 1. Hold reset for 3 cycles with req_valid = 1: no strobes.
- Word store addr 0x14, data 7 -> memWrite = 1 for 1 cycle with address 5, write 7; resp_valid in cycle 2. Then word load 0x14 -> memRead for RD_LAT cycles; resp_rdata = 7.
- Memory word 5 = 0x80FF1234:
  - lb 0x14 -> 0xFFFFFF80
  - lbu 0x15 -> 0x000000FF
  - lh 0x16 -> 0x00001234
  - lhu 0x14 -> 0x000080FF
- sb 0x17 data 0xAB over 0x80FF1234 -> read then write 0x80FF12AB. sh 0x14 data 0x5566 -> 0x556612AB. resp_valid in cycle RD_LAT+2.
- Reset asserted during RD of a sub-word store -> memWrite never rises; next request is accepted normally.
- With MEM_ACCESS_MISALIGN_TRAP_EN, lw 0x15 -> resp_err = 1 in cycle 1 with no strobes. Without the macro, the same request reads word 5.
